// File: rtl/axis_mc_master.sv
// axis_mc_master: buffers CH_NUM backend streams in per-channel FIFOs and forwards whole
// packets onto a single AXI-Stream link. Arbitration is round-robin at packet granularity,
// and tid carries the source channel number.
// Optional build macro AXIS_MC_PKT_LIMIT_EN: forces tlast on the MAX_PKT_LEN-th beat of a
// packet. The remaining beats of that channel then go out as a new packet.
module axis_mc_master #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned USER_W      = 2,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned RDY_TIMEOUT = 5,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CH_NUM-1:0]            bk_valid,
  output logic [CH_NUM-1:0]            bk_ready,
  input  logic [CH_NUM*DATA_W-1:0]     bk_data,
  input  logic [CH_NUM*DATA_W/8-1:0]   bk_tstrb,
  input  logic [CH_NUM*DATA_W/8-1:0]   bk_tkeep,
  input  logic [CH_NUM*USER_W-1:0]     bk_tuser,
  input  logic [CH_NUM-1:0]            bk_last,
  output logic [CH_NUM-1:0]            bk_done,
  output logic                         bk_nordy,
  output logic                         axis_tvalid,
  output logic                         axis_tlast,
  output logic [DATA_W-1:0]            axis_tdata,
  output logic [DATA_W/8-1:0]          axis_tstrb,
  output logic [DATA_W/8-1:0]          axis_tkeep,
  output logic [ID_W-1:0]              axis_tid,
  output logic [USER_W-1:0]            axis_tuser,
  input  logic                         axis_tready
);

  localparam int unsigned SW    = DATA_W / 8;
  localparam int unsigned EW    = DATA_W + 2 * SW + USER_W + 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AW + 1;
  localparam int unsigned CW    = 2;  // channel index width; CH_NUM is at most 4
  localparam int unsigned CandW = CW + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // FIFO entry layout: {data, strb, keep, user, last}
  logic [EW-1:0]     mem_q    [CH_NUM][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q [CH_NUM];
  logic [AW-1:0]     rd_ptr_q [CH_NUM];
  logic [CntW-1:0]   count_q  [CH_NUM];
  logic [CH_NUM-1:0] empty, full, wr_en, rd_en;

  state_e          state_q;
  logic [CW-1:0]   grant_q, last_grant_q, next_grant;
  logic [CandW-1:0] cand;
  logic            any_pending;
  logic [EW-1:0]   head;
  logic            head_empty, head_last, handshake, tlast_int;
  logic [7:0]      stall_q;

  // Per-channel FIFO status and write acceptance.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      empty[c] = (count_q[c] == '0);
      full[c]  = (count_q[c] == CntW'(FIFO_DEPTH));
      wr_en[c] = bk_valid[c] && !full[c];
    end
  end

  // Only the granted channel is popped, and only on a handshake.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      rd_en[c] = handshake && (grant_q == CW'(c));
    end
  end

  assign bk_ready = ~full;

  // Pointer and occupancy bookkeeping; reset flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (wr_en[c]) wr_ptr_q[c] <= wr_ptr_q[c] + AW'(1);
        if (rd_en[c]) rd_ptr_q[c] <= rd_ptr_q[c] + AW'(1);
        if (wr_en[c] && !rd_en[c]) begin
          count_q[c] <= count_q[c] + CntW'(1);
        end else if (!wr_en[c] && rd_en[c]) begin
          count_q[c] <= count_q[c] - CntW'(1);
        end
      end
    end
  end

  // FIFO storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (wr_en[c]) begin
        mem_q[c][wr_ptr_q[c]] <= {bk_data[c*DATA_W +: DATA_W], bk_tstrb[c*SW +: SW],
                                  bk_tkeep[c*SW +: SW], bk_tuser[c*USER_W +: USER_W],
                                  bk_last[c]};
      end
    end
  end

  // Round-robin pick: first non-empty channel after the last granted one.
  always_comb begin
    next_grant  = last_grant_q;
    any_pending = 1'b0;
    cand        = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      cand = {1'b0, last_grant_q} + CandW'(i);
      if (cand >= CandW'(CH_NUM)) cand = cand - CandW'(CH_NUM);
      for (int c = 0; c < CH_NUM; c++) begin
        if (!any_pending && (cand == CandW'(c)) && !empty[c]) begin
          any_pending = 1'b1;
          next_grant  = CW'(c);
        end
      end
    end
  end

  // Present the granted channel's FIFO head.
  always_comb begin
    head       = '0;
    head_empty = 1'b1;
    for (int c = 0; c < CH_NUM; c++) begin
      if (grant_q == CW'(c)) begin
        head       = mem_q[c][rd_ptr_q[c]];
        head_empty = empty[c];
      end
    end
  end

  assign head_last   = head[0];
  assign axis_tvalid = (state_q == StSend) && !head_empty;
  assign handshake   = axis_tvalid && axis_tready;

`ifdef AXIS_MC_PKT_LIMIT_EN
  logic [15:0] beat_cnt_q;

  assign tlast_int = head_last || (beat_cnt_q == 16'(MAX_PKT_LEN - 1));

  // Beats already sent in the current packet; any tlast handshake starts a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (handshake) begin
      beat_cnt_q <= tlast_int ? '0 : beat_cnt_q + 16'd1;
    end
  end
`else
  logic [31:0] unused_max_pkt_len;

  assign unused_max_pkt_len = 32'(MAX_PKT_LEN);
  assign tlast_int          = head_last;
`endif

  // Payload is forced to zero whenever no beat is offered.
  always_comb begin
    axis_tdata = '0;
    axis_tstrb = '0;
    axis_tkeep = '0;
    axis_tuser = '0;
    axis_tlast = 1'b0;
    axis_tid   = '0;
    if (axis_tvalid) begin
      {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser} = head[EW-1:1];
      axis_tlast = tlast_int;
      axis_tid   = ID_W'(grant_q);
    end
  end

  assign bk_done = rd_en & {CH_NUM{tlast_int}};

  // Arbiter FSM: the grant stays locked until the tlast beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= CW'(CH_NUM - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_pending) begin
            grant_q <= next_grant;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (handshake && tlast_int) begin
            state_q      <= StIdle;
            last_grant_q <= grant_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating count of consecutive cycles in which a beat was offered but not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (axis_tvalid && !axis_tready) begin
      if (stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
    end else begin
      stall_q <= '0;
    end
  end

  assign bk_nordy = (stall_q >= 8'(RDY_TIMEOUT));

endmodule

// File: tb/tb_axis_mc_master.sv
// Directed bench for axis_mc_master with a per-channel scoreboard. Accepted backend writes
// are queued per channel, and every AXIS handshake pops and compares the queue head.
module tb_axis_mc_master;

  localparam int unsigned DW  = 32;
  localparam int unsigned UW  = 2;
  localparam int unsigned IW  = 2;
  localparam int unsigned CH  = 2;
  localparam int unsigned TMO = 5;
`ifdef AXIS_MC_PKT_LIMIT_EN
  localparam int unsigned LIMIT = 4;
`else
  localparam int unsigned LIMIT = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     bk_valid;
  logic [CH-1:0]     bk_ready;
  logic [CH*DW-1:0]  bk_data;
  logic [CH*DW/8-1:0] bk_tstrb;
  logic [CH*DW/8-1:0] bk_tkeep;
  logic [CH*UW-1:0]  bk_tuser;
  logic [CH-1:0]     bk_last;
  logic [CH-1:0]     bk_done;
  logic              bk_nordy;
  logic              axis_tvalid;
  logic              axis_tlast;
  logic [DW-1:0]     axis_tdata;
  logic [DW/8-1:0]   axis_tstrb;
  logic [DW/8-1:0]   axis_tkeep;
  logic [IW-1:0]     axis_tid;
  logic [UW-1:0]     axis_tuser;
  logic              axis_tready;

  axis_mc_master #(
    .DATA_W      (DW),
    .USER_W      (UW),
    .ID_W        (IW),
    .CH_NUM      (CH),
    .FIFO_DEPTH  (8),
    .RDY_TIMEOUT (TMO),
    .MAX_PKT_LEN (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bk_valid    (bk_valid),
    .bk_ready    (bk_ready),
    .bk_data     (bk_data),
    .bk_tstrb    (bk_tstrb),
    .bk_tkeep    (bk_tkeep),
    .bk_tuser    (bk_tuser),
    .bk_last     (bk_last),
    .bk_done     (bk_done),
    .bk_nordy    (bk_nordy),
    .axis_tvalid (axis_tvalid),
    .axis_tlast  (axis_tlast),
    .axis_tdata  (axis_tdata),
    .axis_tstrb  (axis_tstrb),
    .axis_tkeep  (axis_tkeep),
    .axis_tid    (axis_tid),
    .axis_tuser  (axis_tuser),
    .axis_tready (axis_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  int          stall_m   = 0;
  int          pkt_beats = 0;
  int          done_cnt  = 0;
  logic        at_neg    = 1'b0;
  // Entry: {user, keep, strb, data, last}
  logic [42:0] q0[$];
  logic [42:0] q1[$];
  int          tid_log[$];
  int          hs_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input logic [31:0] d, input logic l);
    bk_valid[ch]          = 1'b1;
    bk_data[ch*32 +: 32]  = d;
    bk_tstrb[ch*4 +: 4]   = d[3:0];
    bk_tkeep[ch*4 +: 4]   = d[7:4];
    bk_tuser[ch*2 +: 2]   = d[9:8];
    bk_last[ch]           = l;
  endtask

  task automatic idle_in();
    bk_valid = '0;
    bk_last  = '0;
  endtask

  task automatic peek();
    @(negedge clk);
    at_neg = 1'b1;
  endtask

  // One clock: compare outputs at the falling edge, update the model, cross the rising edge.
  task automatic cycle();
    logic [42:0] e;
    logic        hs;
    logic        avail;
    logic        exp_last;
    logic [1:0]  exp_done;
    if (!at_neg) @(negedge clk);
    at_neg   = 1'b0;
    hs       = axis_tvalid && axis_tready;
    exp_done = '0;
    if (hs) begin
      avail = 1'b0;
      e     = '0;
      if (axis_tid == 2'd0 && q0.size() > 0) begin
        e = q0.pop_front();
        avail = 1'b1;
      end else if (axis_tid == 2'd1 && q1.size() > 0) begin
        e = q1.pop_front();
        avail = 1'b1;
      end
      check("beat_expected", {63'd0, avail}, 64'd1);
      exp_last = e[0] || (LIMIT != 0 && pkt_beats + 1 == LIMIT);
      check("tdata", axis_tdata, e[32:1]);
      check("tstrb", axis_tstrb, e[36:33]);
      check("tkeep", axis_tkeep, e[40:37]);
      check("tuser", axis_tuser, e[42:41]);
      check("tlast", axis_tlast, exp_last);
      if (avail) exp_done[axis_tid[0]] = exp_last;
      pkt_beats = exp_last ? 0 : pkt_beats + 1;
      tid_log.push_back(int'(axis_tid));
      hs_cyc.push_back(cyc);
    end else if (!axis_tvalid) begin
      check("idle_payload_zero",
            {axis_tlast, axis_tdata, axis_tstrb, axis_tkeep, axis_tid, axis_tuser}, 64'd0);
    end
    check("bk_done", bk_done, exp_done);
    check("bk_nordy", bk_nordy, stall_m >= TMO);
    done_cnt += int'(bk_done[0]);
    if (bk_valid[0] && bk_ready[0])
      q0.push_back({bk_tuser[1:0], bk_tkeep[3:0], bk_tstrb[3:0], bk_data[31:0], bk_last[0]});
    if (bk_valid[1] && bk_ready[1])
      q1.push_back({bk_tuser[3:2], bk_tkeep[7:4], bk_tstrb[7:4], bk_data[63:32], bk_last[1]});
    if (axis_tvalid && !axis_tready) stall_m = (stall_m == 255) ? 255 : stall_m + 1;
    else stall_m = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || axis_tvalid) && n < max_cyc) begin
      cycle();
      n++;
    end
    check("drain_in_budget", q0.size() + q1.size(), 64'd0);
  endtask

  task automatic apply_reset();
    idle_in();
    rst_n = 1'b0;
    #1;
    check("rst_bk_ready", bk_ready, 2'b11);
    check("rst_tvalid", axis_tvalid, 1'b0);
    check("rst_payload",
          {axis_tlast, axis_tdata, axis_tstrb, axis_tkeep, axis_tid, axis_tuser}, 64'd0);
    check("rst_bk_done", bk_done, 2'b00);
    check("rst_bk_nordy", bk_nordy, 1'b0);
    q0.delete();
    q1.delete();
    stall_m   = 0;
    pkt_beats = 0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    at_neg = 1'b0;
  endtask

  initial begin
    int exp_dones;
    rst_n       = 1'b0;
    bk_valid    = '0;
    bk_data     = '0;
    bk_tstrb    = '0;
    bk_tkeep    = '0;
    bk_tuser    = '0;
    bk_last     = '0;
    axis_tready = 1'b0;
    #1;
    apply_reset();

    // Single beat: two-cycle latency, tid 0, tlast and bk_done together.
    axis_tready = 1'b1;
    drive(0, 32'hA5A5A5A5, 1'b1);
    cycle();
    idle_in();
    peek();
    check("t1_latency_low", axis_tvalid, 1'b0);
    cycle();
    peek();
    check("t1_tvalid", axis_tvalid, 1'b1);
    check("t1_tid", axis_tid, 2'd0);
    check("t1_tlast", axis_tlast, 1'b1);
    check("t1_done", bk_done, 2'b01);
    check("t1_data", axis_tdata, 32'hA5A5A5A5);
    cycle();
    drain(10);

    // Two simultaneous 3-beat packets: whole packets, ch0 first, one bubble between.
    apply_reset();
    tid_log.delete();
    hs_cyc.delete();
    for (int b = 0; b < 3; b++) begin
      drive(0, 32'h1000 + b, b == 2);
      drive(1, 32'h2000 + b, b == 2);
      cycle();
    end
    idle_in();
    drain(30);
    check("t2_beats", tid_log.size(), 6);
    if (tid_log.size() == 6) begin
      for (int i = 0; i < 6; i++) check("t2_tid_order", tid_log[i], (i < 3) ? 0 : 1);
      check("t2_full_rate", hs_cyc[1] - hs_cyc[0], 1);
      check("t2_bubble", hs_cyc[3] - hs_cyc[2], 2);
    end

    // Fill ch0 with tready low: backpressure, timeout flag, then in-order drain.
    tid_log.delete();
    axis_tready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      drive(0, 32'h3000 + b, b == 7);
      cycle();
    end
    idle_in();
    peek();
    check("t3_full_ready", bk_ready[0], 1'b0);
    check("t3_nordy_set", bk_nordy, 1'b1);
    check("t3_tvalid_held", axis_tvalid, 1'b1);
    check("t3_head_hold", axis_tdata, 32'h3000);
    cycle();
    axis_tready = 1'b1;
    cycle();
    peek();
    check("t3_ready_reopen", bk_ready[0], 1'b1);
    check("t3_nordy_clear", bk_nordy, 1'b0);
    drain(20);
    check("t3_beats", tid_log.size(), 8);

    // ch1 pauses mid-packet while ch0 waits: grant stays with ch1 until its tlast.
    tid_log.delete();
    drive(1, 32'h4000, 1'b0);
    drive(0, 32'h5000, 1'b1);
    cycle();
    idle_in();
    drive(1, 32'h4001, 1'b0);
    cycle();
    idle_in();
    cycle();
    cycle();
    peek();
    check("t4_pause_tvalid_low", axis_tvalid, 1'b0);
    cycle();
    drive(1, 32'h4002, 1'b0);
    cycle();
    drive(1, 32'h4003, 1'b1);
    cycle();
    idle_in();
    drain(20);
    check("t4_beats", tid_log.size(), 5);
    if (tid_log.size() == 5) begin
      for (int i = 0; i < 5; i++) check("t4_tid_order", tid_log[i], (i < 4) ? 1 : 0);
    end

    // Reset with a partial packet buffered: flushed, and ch0 wins first afterwards.
    tid_log.delete();
    axis_tready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(1, 32'h6000 + b, 1'b0);
      cycle();
    end
    idle_in();
    cycle();
    peek();
    check("t5_pre_tvalid", axis_tvalid, 1'b1);
    check("t5_pre_tid", axis_tid, 2'd1);
    apply_reset();
    tid_log.delete();
    axis_tready = 1'b1;
    drive(1, 32'h7000, 1'b1);
    drive(0, 32'h7100, 1'b1);
    cycle();
    idle_in();
    drain(20);
    check("t5_beats", tid_log.size(), 2);
    if (tid_log.size() == 2) begin
      check("t5_first_grant", tid_log[0], 0);
      check("t5_second_grant", tid_log[1], 1);
    end

    // 6-beat packet: split at the beat limit when enabled, a single packet otherwise.
    tid_log.delete();
    done_cnt  = 0;
    exp_dones = (LIMIT != 0) ? 2 : 1;
    for (int b = 0; b < 6; b++) begin
      drive(0, 32'h8000 + b, b == 5);
      cycle();
    end
    idle_in();
    drain(30);
    check("t6_beats", tid_log.size(), 6);
    check("t6_done_pulses", done_cnt, exp_dones);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
